// File: rtl/uart_hex_entry.sv
// Hex number entry engine for the UART console: collects hex digits from RX, echoes them on TX
// and reports the value on CR (or abandons it on ESC). Define UART_HEX_BKSP_EN for BS/DEL editing.
module uart_hex_entry #(
  parameter int NUM_W      = 32,
  parameter int MAX_DIGITS = 8,
  parameter int ECHO_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic [NUM_W-1:0]                num_out,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt,
  output logic                            o_Tx_DV,
  output logic [7:0]                      o_Tx_Byte,
  input  logic                            i_Tx_Active,
  input  logic                            i_Tx_Done,
  input  logic                            i_Rx_DV,
  input  logic [7:0]                      i_Rx_Byte
);

  localparam int            CW      = $clog2(MAX_DIGITS+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [7:0]    CH_BEL  = 8'h07;
  localparam logic [7:0]    CH_LF   = 8'h0A;
  localparam logic [7:0]    CH_CR   = 8'h0D;
  localparam logic [7:0]    CH_ESC  = 8'h1B;
`ifdef UART_HEX_BKSP_EN
  localparam logic [7:0]    CH_BS   = 8'h08;
  localparam logic [7:0]    CH_SP   = 8'h20;
  localparam logic [7:0]    CH_DEL  = 8'h7F;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RX, S_TX_REQ, S_TX_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             fin_q, fin_d;
  logic             abt_q, abt_d;
  logic [1:0]       txn_q, txn_d;
  logic [7:0]       txq_q [3];
  logic [7:0]       txq_d [3];
  logic [4:0]       rx_hex;

  // The TX core's busy flag is informational; sequencing relies on i_Tx_Done alone.
  logic unused_tx_active;
  assign unused_tx_active = i_Tx_Active;

  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    num_d     = num_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    fin_d     = fin_q;
    abt_d     = abt_q;
    txn_d     = txn_q;
    txq_d     = txq_q;
    rx_hex    = hex_decode(i_Rx_Byte);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          fin_d   = 1'b0;
          abt_d   = 1'b0;
          txn_d   = 2'd0;
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (i_Rx_DV) begin
          if (rx_hex[4]) begin
            if (cnt_q < MAX_CNT) begin
              acc_d = {acc_q[NUM_W-5:0], rx_hex[3:0]};
              cnt_d = cnt_q + CW'(1);
              if (ECHO_EN != 0) begin
                txq_d[0] = i_Rx_Byte;
                txn_d    = 2'd1;
                state_d  = S_TX_REQ;
              end
            end else begin
              txq_d[0] = CH_BEL;
              txn_d    = 2'd1;
              state_d  = S_TX_REQ;
            end
          end else if (i_Rx_Byte == CH_CR || i_Rx_Byte == CH_ESC) begin
            if (i_Rx_Byte == CH_ESC) begin
              acc_d = '0;
              abt_d = 1'b1;
            end
            txq_d[0] = CH_CR;
            txq_d[1] = CH_LF;
            txn_d    = 2'd2;
            fin_d    = 1'b1;
            state_d  = S_TX_REQ;
          end
`ifdef UART_HEX_BKSP_EN
          else if (i_Rx_Byte == CH_BS || i_Rx_Byte == CH_DEL) begin
            if (cnt_q != '0) begin
              acc_d    = acc_q >> 4;
              cnt_d    = cnt_q - CW'(1);
              txq_d[0] = CH_BS;
              txq_d[1] = CH_SP;
              txq_d[2] = CH_BS;
              txn_d    = 2'd3;
            end else begin
              txq_d[0] = CH_BEL;
              txn_d    = 2'd1;
            end
            state_d = S_TX_REQ;
          end
`endif
        end
      end
      S_TX_REQ: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = txq_q[0];
        state_d   = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_Tx_Done) state_d = S_NEXT;
      end
      S_NEXT: begin
        txq_d[0] = txq_q[1];
        txq_d[1] = txq_q[2];
        txn_d    = txn_q - 2'd1;
        if (txn_q != 2'd1) begin
          state_d = S_TX_REQ;
        end else if (fin_q) begin
          // Result and done are registered here so done lands one cycle later, in FINISH.
          num_d     = acc_q;
          aborted_d = abt_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_FINISH;
        end else begin
          state_d = S_WAIT_RX;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      num_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      fin_q     <= 1'b0;
      abt_q     <= 1'b0;
      txn_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      num_q     <= num_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      fin_q     <= fin_d;
      abt_q     <= abt_d;
      txn_q     <= txn_d;
    end
  end

  // Queue contents are only read while txn_q says they are valid.
  always_ff @(posedge clk) begin
    txq_q <= txq_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign num_out   = num_q;
  assign digit_cnt = cnt_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_hex_entry.sv
// Self-checking bench for uart_hex_entry: directed entries plus randomized byte streams
// compared against a digit-list reference model and a 10-cycle TX core model.
module tb_uart_hex_entry;
  localparam int NUM_W      = 32;
  localparam int MAX_DIGITS = 8;
  localparam int ECHO_EN    = 1;
  localparam int CW         = $clog2(MAX_DIGITS+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, aborted, o_Tx_DV;
  logic [NUM_W-1:0] num_out;
  logic [CW-1:0]    digit_cnt;
  logic [7:0]       o_Tx_Byte;
  logic             i_Tx_Active = 1'b0;
  logic             i_Tx_Done = 1'b0;
  logic             i_Rx_DV = 1'b0;
  logic [7:0]       i_Rx_Byte = 8'h00;

  uart_hex_entry #(.NUM_W(NUM_W), .MAX_DIGITS(MAX_DIGITS), .ECHO_EN(ECHO_EN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .aborted(aborted),
    .num_out(num_out), .digit_cnt(digit_cnt), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // TX core model: byte completes 10 cycles after o_Tx_DV.
  logic [7:0] got_tx[$];
  int         got_cyc[$];
  int         tx_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  int         last_done_cyc = 0;

  always @(negedge clk) begin
    i_Tx_Done = 1'b0;
    if (rst_n !== 1'b1) begin
      tx_cnt      = 0;
      i_Tx_Active = 1'b0;
    end else if (o_Tx_DV === 1'b1) begin
      got_tx.push_back(o_Tx_Byte);
      got_cyc.push_back(cyc);
      cur_byte    = o_Tx_Byte;
      tx_cnt      = 10;
      i_Tx_Active = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        check_val("tx_byte_stable", o_Tx_Byte, cur_byte);
        i_Tx_Done     = 1'b1;
        i_Tx_Active   = 1'b0;
        last_done_cyc = cyc;
      end
    end
  end

  int done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      check_val("busy_with_done", busy, 0);
      check_val("done_latency", cyc - last_done_cyc, 2);
    end
  end

  // Reference model: the entry is a list of digits; the value is derived from the list.
  logic [3:0] dq[$];
  logic [7:0] exp_tx[$];
  logic       exp_abort;
  logic [7:0] stim[$];

  function automatic int hex_val(input logic [7:0] b);
    string digs = "0123456789abcdef";
    logic [7:0] c = b;
    if (c >= "A" && c <= "Z") c = c + 8'd32;
    for (int i = 0; i < 16; i++) if (digs[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [63:0] model_value();
    logic [63:0] v = 64'd0;
    foreach (dq[i]) v = v * 16 + 64'(dq[i]);
    return v & ((64'd1 << NUM_W) - 64'd1);
  endfunction

  task automatic model_byte(input logic [7:0] b, output int n);
    int h;
    n = 0;
    h = hex_val(b);
    if (h >= 0) begin
      if (dq.size() < MAX_DIGITS) begin
        dq.push_back(4'(h));
        if (ECHO_EN != 0) begin exp_tx.push_back(b); n = 1; end
      end else begin
        exp_tx.push_back(8'h07); n = 1;
      end
    end else if (b == 8'h0D || b == 8'h1B) begin
      if (b == 8'h1B) begin dq.delete(); exp_abort = 1'b1; end
      exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A); n = 2;
    end
`ifdef UART_HEX_BKSP_EN
    else if (b == 8'h08 || b == 8'h7F) begin
      if (dq.size() > 0) begin
        void'(dq.pop_back());
        exp_tx.push_back(8'h08); exp_tx.push_back(8'h20); exp_tx.push_back(8'h08); n = 3;
      end else begin
        exp_tx.push_back(8'h07); n = 1;
      end
    end
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int n);
    int base, rx_cyc, waited;
    base = got_tx.size();
    @(posedge clk); #1;
    i_Rx_DV = 1'b1; i_Rx_Byte = b; rx_cyc = cyc;
    @(posedge clk); #1;
    i_Rx_DV = 1'b0;
    waited = 0;
    while (!(got_tx.size() >= base + n && tx_cnt == 0 && i_Tx_Done == 1'b0) && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    check_val($sformatf("tx_count_%02h", b), got_tx.size() - base, n);
    if (n > 0 && got_cyc.size() > base) check_val("rx_to_txdv", got_cyc[base] - rx_cyc, 2);
  endtask

  task automatic model_clear();
    dq.delete(); exp_tx.delete(); got_tx.delete(); got_cyc.delete();
    exp_abort = 1'b0;
  endtask

  task automatic run_entry(input string name, input bit poke_start);
    int n, dc0;
    model_clear();
    dc0 = done_cnt;
    pulse_start();
    check_val({name, "_busy_start"}, busy, 1);
    check_val({name, "_cnt_start"}, digit_cnt, 0);
    for (int i = 0; i < stim.size(); i++) begin
      model_byte(stim[i], n);
      send_byte(stim[i], n);
      if (poke_start && i == 0 && stim.size() > 1) begin
        pulse_start();
        check_val({name, "_busy_restart"}, busy, 1);
      end
    end
    check_val({name, "_done"}, done_cnt - dc0, 1);
    check_val({name, "_num"}, num_out, model_value());
    check_val({name, "_aborted"}, aborted, exp_abort);
    check_val({name, "_busy_end"}, busy, 0);
    if (!exp_abort) check_val({name, "_digit_cnt"}, digit_cnt, dq.size());
    check_val({name, "_tx_len"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      check_val($sformatf("%s_tx%0d", name, i), (i < got_tx.size()) ? got_tx[i] : 8'hxx, exp_tx[i]);
  endtask

  task automatic load(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    string hexs = "0123456789abcdefABCDEF";
    string others = "xg- Z!";
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_aborted", aborted, 0);
    check_val("rst_txdv", o_Tx_DV, 0);
    check_val("rst_num", num_out, 0);
    check_val("rst_cnt", digit_cnt, 0);
    check_val("rst_txbyte", o_Tx_Byte, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    load("1A2b"); stim.push_back(8'h0D); run_entry("basic", 0);
    check_val("basic_value", num_out, 32'h00001A2B);
    load("123456789"); stim.push_back(8'h0D); run_entry("limit", 0);
    check_val("limit_value", num_out, 32'h12345678);
    load("FF"); stim.push_back(8'h1B); run_entry("esc", 0);
    check_val("esc_aborted", aborted, 1);
    load("AB"); stim.push_back(8'h08); stim.push_back("C"); stim.push_back(8'h0D);
    run_entry("bksp", 0);
    load("x-"); stim.push_back(8'h0D); run_entry("nodigits", 0);
    check_val("nodigits_value", num_out, 0);

    // Reset in the middle of an entry while an echo is in flight.
    model_clear();
    pulse_start();
    model_byte("3", n); send_byte("3", n);
    model_byte("5", n); send_byte("5", n);
    @(posedge clk); #1 i_Rx_DV = 1'b1; i_Rx_Byte = "9";
    @(posedge clk); #1 i_Rx_DV = 1'b0;
    repeat (3) @(posedge clk);
    check_val("rst_mid_dv_seen", got_tx.size(), 3);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_txdv", o_Tx_DV, 0);
    check_val("rst_mid_num", num_out, 0);
    check_val("rst_mid_cnt", digit_cnt, 0);
    base = got_tx.size();
    repeat (20) @(posedge clk);
    check_val("rst_mid_no_reissue", got_tx.size() - base, 0);
    stim.delete(); stim.push_back("7"); stim.push_back(8'h0D);
    run_entry("after_rst", 0);
    check_val("after_rst_value", num_out, 7);

    for (int e = 0; e < 20; e++) begin
      int len;
      stim.delete();
      len = $urandom_range(0, 11);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          6:       stim.push_back(others[$urandom_range(0, 5)]);
          7:       stim.push_back(8'h08);
          8:       stim.push_back(8'h7F);
          default: stim.push_back(hexs[$urandom_range(0, 21)]);
        endcase
      end
      stim.push_back(($urandom_range(0, 4) == 0) ? 8'h1B : 8'h0D);
      run_entry($sformatf("rnd%0d", e), (e % 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_hex_entry.md
Name: uart_hex_entry

Overview:
- Parametrised hex-number entry engine for the UART console.
- Takes a start request from the macro sequencer, then collects hex digits from the UART receiver.
- Echoes each accepted character and enforces a digit limit. The entry ends on CR, or is abandoned on ESC; either way the block finishes with CR/LF and reports the value.
- Sits between the top-level macro state machine and the UART TX/RX byte cores. It replaces fixed 32-bit address/length entry with width/depth-configurable entry, limit checking, bell feedback and abort.

Parameters:
- NUM_W, 32, width of the returned value (8..64).
- MAX_DIGITS, 8, max hex digits accepted (1..NUM_W/4).
- ECHO_EN, 1, 1 = echo accepted digits, 0 = silent entry (BEL and CR/LF still sent).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin an entry; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at entry completion
- aborted  out  1  valid with done; 1 = ESC abort
- num_out  out  NUM_W  entered value, updated at done, held otherwise
- digit_cnt  out  $clog2(MAX_DIGITS+1)  digits in the current entry
- o_Tx_DV  out  1  one-cycle TX request
- o_Tx_Byte  out  8  TX byte, stable from o_Tx_DV until i_Tx_Done
- i_Tx_Active  in  1  TX core busy
- i_Tx_Done  in  1  TX core byte-complete pulse
- i_Rx_DV  in  1  RX byte-valid pulse
- i_Rx_Byte  in  8  received byte

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, aborted, o_Tx_DV = 0; num_out, digit_cnt, accumulator = 0; o_Tx_Byte = 8'h00.
- States: IDLE, WAIT_RX, TX_REQ, TX_WAIT, NEXT, FINISH.
- IDLE: start=1 -> clear accumulator and digit_cnt, busy=1, go to WAIT_RX.
- WAIT_RX: acts on i_Rx_DV only.
  - Hex digit ('0'-'9', 'A'-'F', 'a'-'f') with digit_cnt<MAX_DIGITS: acc = (acc<<4)|nibble, truncated to NUM_W; digit_cnt+1; queue echo of the byte as received if ECHO_EN, else stay in WAIT_RX.
  - Hex digit with digit_cnt==MAX_DIGITS: value unchanged; queue BEL (8'h07).
  - CR (8'h0D): queue CR,LF; set finish flag.
  - ESC (8'h1B): clear acc; set abort flag; queue CR,LF; set finish flag.
  - Any other byte: ignored, no TX.
- TX sequencing, for each queued byte:
  - TX_REQ drives o_Tx_DV=1 for exactly one cycle.
  - TX_WAIT waits for i_Tx_Done; i_Tx_Active is monitoring only.
  - NEXT pops the queue (max 3 entries). Queue empty -> FINISH if finish flag set, else WAIT_RX.
- FINISH: num_out<=acc, aborted<=abort flag, done=1 for one cycle, busy=0, return to IDLE.
- done and busy never high in the same cycle; the first start is accepted in the cycle after done.
- RX bytes arriving outside WAIT_RX are dropped (no RX buffering); the bench must pace input.
- CR with digit_cnt=0: completes normally with num_out=0, aborted=0.
- start while busy: no effect.
- rst_n asserted mid-entry: immediate return to reset values; any TX byte in flight is abandoned, and o_Tx_DV is never re-issued for it.
- Latency: accepted digit -> o_Tx_DV after 2 cycles. Final LF i_Tx_Done -> done after 2 cycles.

Optional Feature:
- Macro UART_HEX_BKSP_EN.
- Defined:
  - BS (8'h08) or DEL (8'h7F) with digit_cnt>0: acc = acc>>4; digit_cnt-1; queue BS, space, BS (3 bytes; sent even if ECHO_EN=0).
  - BS/DEL with digit_cnt=0: queue BEL.
- Undefined: BS/DEL are treated as other bytes (ignored, no TX).

Test Plan:
- Start, send "1A2b" then CR (TX model asserts i_Tx_Done 10 cycles after o_Tx_DV) -> echoes '1','A','2','b',0x0D,0x0A; done pulse; num_out=32'h00001A2B; aborted=0; digit_cnt=4.
- MAX_DIGITS=8: send "123456789" then CR -> 8 echoes, then BEL 0x07 for the '9'; num_out=32'h12345678.
- Send "FF" then ESC -> CR,LF sent; done; aborted=1; num_out=0.
- With UART_HEX_BKSP_EN: send "AB", 0x08, "C", CR -> TX A,B,0x08,0x20,0x08,C,CR,LF; num_out=32'h0000_00AC. Without the macro: same input gives num_out=32'h0000_0ABC and no BS echo.
- Send 'x', '-', then CR with no digits -> no TX for 'x' or '-'; CR,LF sent; done; num_out=0; digit_cnt=0.
- Drop rst_n for 1 cycle after 3 digits while o_Tx_DV sequence is pending -> busy=0, o_Tx_DV=0, num_out=0; next start + "7" + CR gives num_out=7.
